// File: rtl/stepper_motor_bridge_driver.sv
// Two-coil full-step H-bridge driver: Wishbone register file, free-running PWM
// chopper and one dead-time-protected polarity FSM per coil.

module stepper_coil #(
    parameter int DEAD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  req_neg,
    input  logic [DEAD_WIDTH-1:0] dead_time,
    input  logic                  pwm_on,
    output logic [1:0]            state,
    output logic                  p,
    output logic                  n
);
    typedef enum logic [1:0] {OFF = 2'd0, POS = 2'd1, NEG = 2'd2, DEAD = 2'd3} coil_state_t;

    coil_state_t           cur, nxt, tgt;
    logic [DEAD_WIDTH-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= OFF;
            cnt <= '0;
            p   <= 1'b0;
            n   <= 1'b0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
            p   <= (cur == POS) & pwm_on;
            n   <= (cur == NEG) & pwm_on;
        end
    end

    // DEAD exits on the polarity requested in the exit cycle, not the one that caused entry
    always_comb begin
        nxt     = cur;
        cnt_nxt = cnt;
        tgt     = req_neg ? NEG : POS;
        if (!en) begin
            nxt     = OFF;
            cnt_nxt = '0;
        end else begin
            case (cur)
                OFF: begin
                    nxt     = DEAD;
                    cnt_nxt = dead_time;
                end
                POS, NEG: begin
                    if (cur != tgt) begin
                        nxt     = DEAD;
                        cnt_nxt = dead_time;
                    end
                end
                default: begin
                    if (cnt == '0) nxt = tgt;
                    else           cnt_nxt = cnt - 1'b1;
                end
            endcase
        end
    end

    assign state = cur;
endmodule

module stepper_motor_bridge_driver #(
    parameter int                    WB_ADR_WIDTH     = 8,
    parameter int                    WB_DAT_WIDTH     = 32,
    parameter int                    WB_SEL_WIDTH     = WB_DAT_WIDTH / 8,
    parameter int                    PWM_WIDTH        = 8,
    parameter int                    DEAD_WIDTH       = 8,
    parameter logic [WB_DAT_WIDTH-1:0] INIT_CTL_CONTROL = '0,
    parameter logic [PWM_WIDTH-1:0]  INIT_DUTY        = '1,
    parameter logic [DEAD_WIDTH-1:0] INIT_DEAD_TIME   = DEAD_WIDTH'(4)
) (
    input  logic                    reset,
    input  logic                    clk,
    input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
    input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic                    s_wb_we_i,
    input  logic                    s_wb_stb_i,
    output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
    output logic                    s_wb_ack_o,
    input  logic                    motor_en,
    input  logic [1:0]              motor_phase,
    output logic                    coil_a_p,
    output logic                    coil_a_n,
    output logic                    coil_b_p,
    output logic                    coil_b_n
);
    localparam int NUM_COILS = 2;
    localparam logic [31:0]             CORE_ID     = 32'h527A3515;
    localparam logic [WB_ADR_WIDTH-1:0] ADR_ID      = WB_ADR_WIDTH'(8'h00);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL     = WB_ADR_WIDTH'(8'h04);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_DUTY    = WB_ADR_WIDTH'(8'h10);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_DEAD    = WB_ADR_WIDTH'(8'h12);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS  = WB_ADR_WIDTH'(8'h14);

    logic                  ctl;
    logic [PWM_WIDTH-1:0]  duty, pwm_cnt;
    logic [DEAD_WIDTH-1:0] dead_time;
    logic                  wr, en, pwm_on;
    logic [NUM_COILS-1:0]  req_neg, p, n;
    logic [NUM_COILS-1:0][1:0] coil_state;
    logic                  unused;

    assign unused = ^{s_wb_dat_i, s_wb_sel_i};
    assign wr     = s_wb_stb_i & s_wb_we_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl       <= INIT_CTL_CONTROL[0];
            duty      <= INIT_DUTY;
            dead_time <= INIT_DEAD_TIME;
        end else if (wr) begin
            if (s_wb_adr_i == ADR_CTL && s_wb_sel_i[0]) ctl <= s_wb_dat_i[0];
            for (int b = 0; b < PWM_WIDTH; b++)
                if (s_wb_adr_i == ADR_DUTY && s_wb_sel_i[b/8]) duty[b] <= s_wb_dat_i[b];
            for (int b = 0; b < DEAD_WIDTH; b++)
                if (s_wb_adr_i == ADR_DEAD && s_wb_sel_i[b/8]) dead_time[b] <= s_wb_dat_i[b];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign s_wb_ack_o = s_wb_stb_i;
    always_comb begin
        s_wb_dat_o = '0;
        case (s_wb_adr_i)
            ADR_ID:     s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
            ADR_CTL:    s_wb_dat_o = WB_DAT_WIDTH'(ctl);
            ADR_DUTY:   s_wb_dat_o = WB_DAT_WIDTH'(duty);
            ADR_DEAD:   s_wb_dat_o = WB_DAT_WIDTH'(dead_time);
            ADR_STATUS: s_wb_dat_o = WB_DAT_WIDTH'({coil_state[1], coil_state[0]});
            default:    s_wb_dat_o = '0;
        endcase
    end

    assign en         = ctl & motor_en;
    assign pwm_on     = pwm_cnt < duty;
    assign req_neg[0] = motor_phase[1];
    assign req_neg[1] = motor_phase[1] ^ motor_phase[0];

    for (genvar c = 0; c < NUM_COILS; c++) begin : g_coil
        stepper_coil #(.DEAD_WIDTH(DEAD_WIDTH)) u_coil (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .req_neg   (req_neg[c]),
            .dead_time (dead_time),
            .pwm_on    (pwm_on),
            .state     (coil_state[c]),
            .p         (p[c]),
            .n         (n[c])
        );
    end

    assign coil_a_p = p[0];
    assign coil_a_n = n[0];
    assign coil_b_p = p[1];
    assign coil_b_n = n[1];
endmodule

// File: tb/tb_stepper_motor_bridge_driver.sv
// Randomized bench for stepper_motor_bridge_driver against a coil-behaviour model
// (off / dead-with-cycles-left / driving-polarity) plus directed register and timing checks.

module tb_stepper_motor_bridge_driver;
    logic        clk = 1'b0, reset = 1'b1;
    logic [7:0]  adr = '0;
    logic [31:0] dat = '0, dat_o;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, stb = 1'b0, ack;
    logic        motor_en = 1'b0;
    logic [1:0]  motor_phase = '0;
    logic        coil_a_p, coil_a_n, coil_b_p, coil_b_n;

    int checks = 0, failures = 0;

    // model: pol -1 none / 0 pos / 1 neg; hold>0 = dead cycles still to spend
    int pol[2], hold[2], pwm, duty_m, dead_m;
    bit mp[2], mn[2], ctl_m;

    stepper_motor_bridge_driver dut (
        .reset(reset), .clk(clk),
        .s_wb_adr_i(adr), .s_wb_dat_i(dat), .s_wb_sel_i(sel), .s_wb_we_i(we), .s_wb_stb_i(stb),
        .s_wb_dat_o(dat_o), .s_wb_ack_o(ack),
        .motor_en(motor_en), .motor_phase(motor_phase),
        .coil_a_p(coil_a_p), .coil_a_n(coil_a_n), .coil_b_p(coil_b_p), .coil_b_n(coil_b_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mstat(int i);
        if (hold[i] > 0) return 3;
        if (pol[i] == 0) return 1;
        if (pol[i] == 1) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] mread(logic [7:0] a);
        case (a)
            8'h00: return 32'h527A3515;
            8'h04: return {31'b0, ctl_m};
            8'h10: return duty_m;
            8'h12: return dead_m;
            8'h14: return (mstat(1) << 2) | mstat(0);
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pol[i] = -1; hold[i] = -1; mp[i] = 0; mn[i] = 0;
        end
        pwm = 0; duty_m = 255; dead_m = 4; ctl_m = 0;
    endtask

    task automatic model_step();
        bit en, pon;
        int req[2];
        en  = ctl_m & motor_en;
        req[0] = motor_phase[1];
        req[1] = motor_phase[1] ^ motor_phase[0];
        pon = pwm < duty_m;
        for (int i = 0; i < 2; i++) begin
            mp[i] = (mstat(i) == 1) && pon;
            mn[i] = (mstat(i) == 2) && pon;
            if (!en) begin
                pol[i] = -1; hold[i] = -1;
            end else if (hold[i] > 0) begin
                hold[i]--;
                if (hold[i] == 0) begin pol[i] = req[i]; hold[i] = -1; end
            end else if (pol[i] < 0) begin
                hold[i] = dead_m + 1;
            end else if (pol[i] != req[i]) begin
                pol[i] = -1; hold[i] = dead_m + 1;
            end
        end
        pwm = (pwm + 1) % 256;
        if (stb && we && sel[0]) begin
            case (adr)
                8'h04: ctl_m = dat[0];
                8'h10: duty_m = dat[7:0];
                8'h12: dead_m = dat[7:0];
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk); #1;
        chk("coils", {28'b0, coil_b_n, coil_b_p, coil_a_n, coil_a_p},
            {28'b0, mn[1], mp[1], mn[0], mp[0]});
        chk("excl", {31'b0, (coil_a_p & coil_a_n) | (coil_b_p & coil_b_n)}, 0);
        stb = 0; we = 0;
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        adr = a; dat = d; sel = s; we = 1; stb = 1;
        tick();
    endtask

    task automatic wb_read(input string tag, input logic [7:0] a);
        adr = a; we = 0; stb = 1;
        #1;
        chk(tag, dat_o, mread(a));
        chk("ack", {31'b0, ack}, 1);
        stb = 0;
    endtask

    task automatic do_reset();
        #2 reset = 1;
        #1;
        chk("rst_coils", {28'b0, coil_b_n, coil_b_p, coil_a_n, coil_a_p}, 0);
        adr = 8'h14; stb = 1; #1;
        chk("rst_status", dat_o, 0);
        stb = 0;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    initial begin
        int n, ones;
        model_reset();
        #1;
        chk("rst_coils0", {28'b0, coil_b_n, coil_b_p, coil_a_n, coil_a_p}, 0);
        @(posedge clk); #1;
        reset = 0;

        wb_read("core_id", 8'h00);
        wb_read("ctl_rst", 8'h04);
        wb_read("duty_rst", 8'h10);
        wb_read("dead_rst", 8'h12);
        wb_read("status_rst", 8'h14);
        wb_read("unmapped", 8'h08);
        wb_write(8'h00, 32'hFFFFFFFF, 4'hF);
        wb_read("core_id_ro", 8'h00);
        wb_write(8'h10, 32'h1234, 4'b0001);
        wb_read("duty_sel", 8'h10);
        chk("duty_34", dat_o, 32'h34);
        wb_write(8'h10, 32'hFF, 4'b0001);

        // enable with phase 00: both coils positive from the 7th edge
        wb_write(8'h04, 32'h1, 4'h1);
        tick();
        motor_en = 1;
        n = 0;
        do begin tick(); n++; end while (!coil_a_p && n < 20);
        chk("lat_a", n, 7);
        chk("lat_b", {31'b0, coil_b_p}, 1);
        repeat (10) tick();

        // short B glitch 00->01->00 must never reach coil_b_n
        motor_phase = 2'b01; tick();
        motor_phase = 2'b00;
        ones = 0;
        repeat (20) begin tick(); ones += coil_b_n; end
        chk("b_n_glitch", ones, 0);
        wb_read("status_pos", 8'h14);

        // chopper duty
        wb_write(8'h10, 32'd64, 4'h1);
        repeat (10) tick();
        ones = 0;
        repeat (256) begin tick(); ones += coil_a_p; end
        chk("duty64", ones, 64);

        // drop enable while B is dead, then reset mid-PWM
        wb_write(8'h10, 32'hFF, 4'h1);
        motor_phase = 2'b01; repeat (2) tick();
        wb_read("status_dead", 8'h14);
        motor_en = 0; repeat (3) tick();
        do_reset();
        wb_read("status_post", 8'h14);

        wb_write(8'h04, 32'h1, 4'h1);
        motor_en = 1;
        for (int it = 0; it < 3000; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (it == 1500) begin
                do_reset();
                wb_write(8'h04, 32'h1, 4'h1);
            end else if (r < 12) begin
                motor_phase = 2'($urandom);
                tick();
            end else if (r == 12) begin
                motor_en = ~motor_en;
                tick();
            end else if (r == 13) begin
                wb_write(8'h04, {$urandom, 1'b0} | 32'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
            end else if (r == 14) begin
                wb_write(8'h10, $urandom, 4'($urandom_range(0, 15)));
            end else if (r == 15) begin
                wb_write(8'h12, ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 6)), 4'($urandom_range(0, 15)));
            end else if (r < 19) begin
                logic [7:0] ra;
                case ($urandom_range(0, 6))
                    0: ra = 8'h00; 1: ra = 8'h04; 2: ra = 8'h10; 3: ra = 8'h12;
                    4: ra = 8'h14; 5: ra = 8'h08; default: ra = 8'($urandom);
                endcase
                wb_read("rand_rd", ra);
                tick();
            end else begin
                if (r == 19 && !motor_en) motor_en = 1;
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stepper_motor_bridge_driver.md
STEPPER_MOTOR_BRIDGE_DRIVER -- requirements
Module: stepper_motor_bridge_driver

Interface
REQ-001 Parameter WB_ADR_WIDTH, default 8: Wishbone address width, in words.
REQ-002 Parameter WB_DAT_WIDTH, default 32: Wishbone data width.
REQ-003 Parameter WB_SEL_WIDTH, default WB_DAT_WIDTH/8: byte-select width.
REQ-004 Parameter PWM_WIDTH, default 8: chopper counter width and duty width.
REQ-005 Parameter DEAD_WIDTH, default 8: dead-time counter width.
REQ-006 Parameters INIT_CTL_CONTROL (default 0), INIT_DUTY (default all-ones) and INIT_DEAD_TIME (default 4) SHALL set the register reset values.
REQ-007 Port reset: input, 1 bit, asynchronous, active-high.
REQ-008 Port clk: input, 1 bit; all logic is in this single clock domain.
REQ-009 Ports s_wb_adr_i/s_wb_dat_i/s_wb_sel_i/s_wb_we_i/s_wb_stb_i: inputs, Wishbone slave request.
REQ-010 Ports s_wb_dat_o (WB_DAT_WIDTH) and s_wb_ack_o (1): outputs, Wishbone slave response.
REQ-011 Port motor_en: input, 1 bit; drive request from the upstream step-phase generator.
REQ-012 Port motor_phase: input, 2 bits; full-step phase from the upstream step-phase generator.
REQ-013 Ports coil_a_p, coil_a_n, coil_b_p, coil_b_n: outputs, 1 bit each, registered H-bridge gate drives.

Function
REQ-014 Register map (word address): 0x00 CORE_ID, read-only 0x527A3515; 0x04 CTL_CONTROL, bit0 enable; 0x10 DUTY, PWM_WIDTH bits; 0x12 DEAD_TIME, DEAD_WIDTH bits; 0x14 STATUS, read-only, bits[1:0] = coil A state, bits[3:2] = coil B state.
REQ-015 Writes SHALL occur when stb&we are high, masked per byte by s_wb_sel_i; writes to read-only or unmapped addresses SHALL be ignored.
REQ-016 s_wb_ack_o SHALL equal s_wb_stb_i combinationally; s_wb_dat_o SHALL be combinational and zero for unmapped addresses.
REQ-017 Effective enable (en) = CTL_CONTROL[0] AND motor_en.
REQ-018 Requested polarity: A = motor_phase[1], B = motor_phase[1] XOR motor_phase[0]; 0 = positive, 1 = negative. This gives sequence 00:A+B+, 01:A+B-, 10:A-B-, 11:A-B+.
REQ-019 Each coil SHALL have an independent FSM with states OFF=0, POS=1, NEG=2, DEAD=3.
REQ-020 Transition, any state with en=0: go to OFF next cycle; dead counter cleared.
REQ-021 Transition, OFF with en=1: go to DEAD and load the dead counter with DEAD_TIME.
REQ-022 Transition, POS/NEG with the requested polarity differing: go to DEAD and load DEAD_TIME.
REQ-023 Transition, DEAD: decrement the counter; at count 0, enter the polarity requested in that cycle, even if the request changed during DEAD.
REQ-024 DEAD_TIME=0 SHALL spend exactly one cycle in DEAD; DEAD_TIME=N SHALL spend N+1 cycles in DEAD.
REQ-025 The PWM counter SHALL be free-running and wrap from 2^PWM_WIDTH-1 to 0; pwm_on = (counter < DUTY).
REQ-026 DUTY=0 SHALL force the coils off; DUTY=all-ones SHALL give (2^PWM_WIDTH-1)/2^PWM_WIDTH on-time.
REQ-027 Output registers: coil_x_p <= (state==POS)&pwm_on; coil_x_n <= (state==NEG)&pwm_on.
REQ-028 Latency: an input change at edge k SHALL update the state at edge k+1 and the outputs at edge k+2.
REQ-029 coil_x_p and coil_x_n SHALL never both be 1 in any cycle, including across reset and register writes.
REQ-030 A DEAD_TIME write during DEAD SHALL NOT affect the running count; it SHALL apply from the next load.

Reset
REQ-031 On reset assertion, all outputs, both FSMs (OFF) and the PWM and dead counters (0) SHALL clear immediately without a clock; registers SHALL take their INIT_* values.
REQ-032 After reset, gate outputs SHALL remain 0 until a full dead-time interval has elapsed with en=1.

Verification
REQ-033 Enable, DUTY=255, DEAD_TIME=4, phase=00 -> coil_a_p=coil_b_p=1 from edge 7 after en rises (1 cycle OFF->DEAD, 5 DEAD, 1 output register); the _n drives stay 0.
REQ-034 Phase 00->01 in steady state -> coil_b_p falls 2 edges later; coil_b_n rises 5 cycles after that; coil A is unaffected.
REQ-035 Phase 00->01->00 within 2 cycles -> B passes through DEAD, then returns to POS; coil_b_n is never 1.
REQ-036 DUTY=64, PWM_WIDTH=8, coil active -> coil_a_p high for exactly 64 of every 256 cycles.
REQ-037 motor_en dropped while in DEAD, then reset pulsed mid-PWM -> all outputs 0 (immediately on reset); STATUS=0; the assertion p&n==0 holds throughout.
REQ-038 Wishbone write DUTY=0x1234 with sel=0b0001 -> DUTY reads 0x34; a CORE_ID read returns 0x527A3515; a write to CORE_ID is ignored.
